// File: rtl/bram_latency_ctrl.sv
// Fixed-latency BRAM controller: requests ride a delay line and act on the array at its end.
// Read results queue in a FWFT response FIFO that is guarded by read credits.
module bram_latency_ctrl #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int LATENCY   = 10,
  parameter int RSP_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [DATA_W/8-1:0] i_req_be,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic [ADDR_W-1:0]   o_rsp_addr,
  output logic                o_busy,
  output logic [5:0]          o_rd_inflight
);

  localparam int BE_W = DATA_W / 8;
  localparam int NS   = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW   = $clog2(RSP_DEPTH + 1);

  logic              w_acc;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_inc;
  logic              w_any_stg;
  logic              w_x_vld;
  logic              w_x_we;
  logic [BE_W-1:0]   w_x_be;
  logic [ADDR_W-1:0] w_x_addr;
  logic [DATA_W-1:0] w_x_wdata;
  logic [31:0]       w_credit_used;

  logic [DATA_W-1:0] r_mem       [2**ADDR_W];
  logic [DATA_W-1:0] r_fifo_data [RSP_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [RSP_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_cnt;
  logic [5:0]        r_rd_inflight;

  assign w_acc = i_req_valid & o_req_ready;

  // LATENCY-1 register stages; the array access itself is the final cycle of the latency.
  generate
    if (LATENCY == 1) begin : g_no_stg
      assign w_x_vld   = w_acc;
      assign w_x_we    = i_req_we;
      assign w_x_be    = i_req_be;
      assign w_x_addr  = i_req_addr;
      assign w_x_wdata = i_req_wdata;
      assign w_any_stg = 1'b0;
    end else begin : g_stg
      logic [NS-1:0]     r_sv;
      logic [NS-1:0]     r_swe;
      logic [BE_W-1:0]   r_sbe   [NS];
      logic [ADDR_W-1:0] r_saddr [NS];
      logic [DATA_W-1:0] r_sdata [NS];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sv <= '0;
        end else begin
          r_sv[0] <= w_acc;
          for (int i = 1; i < NS; i++) r_sv[i] <= r_sv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        r_swe[0]   <= i_req_we;
        r_sbe[0]   <= i_req_be;
        r_saddr[0] <= i_req_addr;
        r_sdata[0] <= i_req_wdata;
        for (int i = 1; i < NS; i++) begin
          r_swe[i]   <= r_swe[i-1];
          r_sbe[i]   <= r_sbe[i-1];
          r_saddr[i] <= r_saddr[i-1];
          r_sdata[i] <= r_sdata[i-1];
        end
      end

      assign w_x_vld   = r_sv[NS-1];
      assign w_x_we    = r_swe[NS-1];
      assign w_x_be    = r_sbe[NS-1];
      assign w_x_addr  = r_saddr[NS-1];
      assign w_x_wdata = r_sdata[NS-1];
      assign w_any_stg = |r_sv;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_x_vld & w_x_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (w_x_be[b]) r_mem[w_x_addr][8*b +: 8] <= w_x_wdata[8*b +: 8];
      end
    end
  end

  assign w_push   = w_x_vld & ~w_x_we;
  assign w_pop    = o_rsp_valid & i_rsp_ready;
  assign w_rd_inc = w_acc & ~i_req_we & (r_rd_inflight != 6'd32);

  // The FIFO entry doubles as the array's output register.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= r_mem[w_x_addr];
      r_fifo_addr[r_wptr] <= w_x_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_cnt         <= '0;
      r_rd_inflight <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(RSP_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(RSP_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      if (w_push & ~w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop & ~w_push) r_cnt <= r_cnt - CW'(1);
      if (w_rd_inc & ~w_push)      r_rd_inflight <= r_rd_inflight + 6'd1;
      else if (w_push & ~w_rd_inc) r_rd_inflight <= r_rd_inflight - 6'd1;
    end
  end

  assign w_credit_used = 32'(r_rd_inflight) + 32'(r_cnt);
  assign o_req_ready   = (w_credit_used < 32'(RSP_DEPTH));
  assign o_rsp_valid   = (r_cnt != '0);
  assign o_rsp_data    = o_rsp_valid ? r_fifo_data[r_rptr] : '0;
  assign o_rsp_addr    = o_rsp_valid ? r_fifo_addr[r_rptr] : '0;
  assign o_busy        = w_any_stg | o_rsp_valid;
  assign o_rd_inflight = r_rd_inflight;

endmodule
